// File: rtl/hazard_byp_ctrl_pkg.sv
// hazard_byp_ctrl_pkg: FSM state encodings, R0 address and default load-use bubble count
package hazard_byp_ctrl_pkg;
  typedef enum logic {HZ_RUN, HZ_LU_STALL} hz_state_e;
  localparam int HZ_R0        = 0;
  localparam int LU_STALL_DEF = 1;
endpackage

// File: rtl/hazard_dst_tracker.sv
// hazard_dst_tracker: destination tracker for the ID_EX (E) and EX_DM (D) slots
module hazard_dst_tracker #(
  parameter int RF_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_e,
  input  logic             adv_d,
  input  logic             kill_e,
  input  logic             id_we,
  input  logic             id_ld,
  input  logic [RF_AW-1:0] id_dst,
  output logic             e_valid,
  output logic             e_we,
  output logic             e_ld,
  output logic [RF_AW-1:0] e_dst,
  output logic             d_valid,
  output logic             d_we,
  output logic [RF_AW-1:0] d_dst
);
  // E takes the ID instruction (or an empty slot on bubble/flush); D takes E; each holds while its stage is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {e_valid, e_we, e_ld, e_dst} <= '0;
      {d_valid, d_we, d_dst}       <= '0;
    end else begin
      if (adv_e) {e_valid, e_we, e_ld, e_dst} <= kill_e ? '0 : {1'b1, id_we, id_ld, id_dst};
      if (adv_d) {d_valid, d_we, d_dst} <= {e_valid, e_we, e_dst};
    end
  end
endmodule

// File: rtl/hazard_byp_ctrl.sv
// hazard_byp_ctrl: bypass selects, load-use/mem-wait stalls, flush bubbles; HAZ_PERF_CNT_EN adds perf counters
module hazard_byp_ctrl
  import hazard_byp_ctrl_pkg::*;
#(
  parameter int RF_AW    = 4,
  parameter int LU_STALL = LU_STALL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RF_AW-1:0] src0_addr_ID,
  input  logic [RF_AW-1:0] src1_addr_ID,
  input  logic             src0_used_ID,
  input  logic             src1_used_ID,
  input  logic [RF_AW-1:0] dst_addr_ID,
  input  logic             we_ID,
  input  logic             ld_ID,
  input  logic             flush_EX,
  input  logic             mem_wait,
  output logic             byp0_EX,
  output logic             byp1_EX,
  output logic             byp0_DM,
  output logic             byp1_DM,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_DM,
  output logic             stall_DM_WB,
  output logic             bubble_ID_EX
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]      perf_lu_cnt,
  output logic [15:0]      perf_mw_cnt
`endif
);
  logic             e_valid, e_we, e_ld, d_valid, d_we;
  logic [RF_AW-1:0] e_dst, d_dst;
  logic             nz0, nz1, m0_e, m1_e, m0_d, m1_d, trig, fl, lu_bub, flush_pend;
  logic [1:0]       cnt, cnt_nx;
  hz_state_e        state, state_nx;

  hazard_dst_tracker #(.RF_AW(RF_AW)) u_trk (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_e  (!stall_ID_EX),
    .adv_d  (!stall_EX_DM),
    .kill_e (bubble_ID_EX),
    .id_we  (we_ID),
    .id_ld  (ld_ID),
    .id_dst (dst_addr_ID),
    .e_valid(e_valid),
    .e_we   (e_we),
    .e_ld   (e_ld),
    .e_dst  (e_dst),
    .d_valid(d_valid),
    .d_we   (d_we),
    .d_dst  (d_dst)
  );

  assign nz0  = src0_addr_ID != RF_AW'(HZ_R0);
  assign nz1  = src1_addr_ID != RF_AW'(HZ_R0);
  assign m0_e = src0_used_ID & e_valid & e_we & (e_dst == src0_addr_ID) & nz0;
  assign m1_e = src1_used_ID & e_valid & e_we & (e_dst == src1_addr_ID) & nz1;
  assign m0_d = src0_used_ID & d_valid & d_we & (d_dst == src0_addr_ID) & nz0;
  assign m1_d = src1_used_ID & d_valid & d_we & (d_dst == src1_addr_ID) & nz1;
  assign trig = e_valid & e_ld & (m0_e | m1_e);
  assign fl   = !mem_wait & (flush_EX | flush_pend);

  // load-use sequencing and stage controls; mem_wait freezes everything, flush overrides load-use
  always_comb begin
    lu_bub       = (state == HZ_RUN) ? trig : (cnt < 2'(LU_STALL));
    state_nx     = mem_wait ? state : ((!fl && lu_bub) ? HZ_LU_STALL : HZ_RUN);
    cnt_nx       = mem_wait ? cnt : ((fl || !lu_bub) ? 2'd0 : cnt + 2'd1);
    stall_IF_ID  = mem_wait | (lu_bub & !fl);
    stall_ID_EX  = mem_wait;
    stall_EX_DM  = mem_wait;
    stall_DM_WB  = mem_wait;
    bubble_ID_EX = !mem_wait & (fl | lu_bub);
  end

  // FSM state, bubble counter and the flush latched across a memory wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HZ_RUN;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      flush_pend <= mem_wait & (flush_pend | flush_EX);
    end
  end

  // bypass selects follow the ID instruction into ID_EX; EX match takes priority over DM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {byp0_EX, byp0_DM, byp1_EX, byp1_DM} <= '0;
    end else if (!stall_ID_EX) begin
      byp0_EX <= m0_e;
      byp0_DM <= m0_d & !m0_e;
      byp1_EX <= m1_e;
      byp1_DM <= m1_d & !m1_e;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic lu_take;
  assign lu_take = !mem_wait & !fl & lu_bub;
  // saturating counts of load-use bubbles actually inserted and of memory-wait cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_cnt <= '0;
      perf_mw_cnt <= '0;
    end else begin
      if (lu_take && perf_lu_cnt != 16'hFFFF) perf_lu_cnt <= perf_lu_cnt + 16'd1;
      if (mem_wait && perf_mw_cnt != 16'hFFFF) perf_mw_cnt <= perf_mw_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_byp_ctrl.sv
// tb_hazard_byp_ctrl: directed scenarios plus randomized run against an instruction-level pipeline model
module tb_hazard_byp_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] s0, s1, dst;
  logic       u0, u1, we, ld, flush, mw;
  logic       byp0_EX, byp1_EX, byp0_DM, byp1_DM;
  logic       stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB, bubble_ID_EX;
  logic [8:0] obs;
  int         checks = 0;
  int         errors = 0;

  typedef struct packed {logic v; logic we; logic ld; logic [3:0] dst;} slot_t;

  hazard_byp_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .src0_addr_ID(s0), .src1_addr_ID(s1), .src0_used_ID(u0), .src1_used_ID(u1),
    .dst_addr_ID(dst), .we_ID(we), .ld_ID(ld), .flush_EX(flush), .mem_wait(mw),
    .byp0_EX(byp0_EX), .byp1_EX(byp1_EX), .byp0_DM(byp0_DM), .byp1_DM(byp1_DM),
    .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX), .stall_EX_DM(stall_EX_DM),
    .stall_DM_WB(stall_DM_WB), .bubble_ID_EX(bubble_ID_EX)
  );

  assign obs = {byp0_EX, byp0_DM, byp1_EX, byp1_DM, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB, bubble_ID_EX};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a0, input logic g0, input logic [3:0] a1, input logic g1,
                       input logic [3:0] d, input logic w, input logic l, input logic f, input logic m);
    s0 = a0; u0 = g0; s1 = a1; u1 = g1; dst = d; we = w; ld = l; flush = f; mw = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(2, 1, 2, 1, 6, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 9'b0) begin errors++; $display("FAIL reset_outputs got %b want %b", obs, 9'b0); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_ex_bypass();
    do_reset();
    drive(1, 1, 2, 1, 3, 1, 0, 0, 0);
    tick();
    drive(3, 1, 1, 1, 4, 1, 0, 0, 0);
    #1;
    checks++;
    if (obs !== 9'b0) begin errors++; $display("FAIL ex_no_stall got %b want %b", obs, 9'b0); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (obs[8:5] !== 4'b1000) begin errors++; $display("FAIL ex_byp got %b want %b", obs[8:5], 4'b1000); end
  endtask

  task automatic test_dm_bypass();
    do_reset();
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(3, 1, 3, 1, 5, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (obs[8:5] !== 4'b0101) begin errors++; $display("FAIL dm_byp got %b want %b", obs[8:5], 4'b0101); end
  endtask

  task automatic test_r0();
    do_reset();
    drive(1, 1, 2, 1, 0, 1, 0, 0, 0);
    tick();
    drive(0, 1, 0, 1, 7, 1, 0, 0, 0);
    #1;
    checks++;
    if (obs[4:0] !== 5'b0) begin errors++; $display("FAIL r0_no_stall got %b want %b", obs[4:0], 5'b0); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (obs[8:5] !== 4'b0) begin errors++; $display("FAIL r0_byp got %b want %b", obs[8:5], 4'b0); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(2, 1, 2, 1, 6, 1, 0, 0, 0);
    #1;
    checks++;
    if (obs !== 9'b0000_1000_1) begin errors++; $display("FAIL lu_bubble got %b want %b", obs, 9'b0000_1000_1); end
    tick();
    #1;
    checks++;
    if (obs[4:0] !== 5'b0) begin errors++; $display("FAIL lu_release got %b want %b", obs[4:0], 5'b0); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (obs[8:5] !== 4'b0101) begin errors++; $display("FAIL lu_dm_byp got %b want %b", obs[8:5], 4'b0101); end
  endtask

  task automatic test_lu_memwait();
    int nb = 0;
    do_reset();
    drive(0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(2, 1, 2, 1, 6, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs[4:0] !== 5'b11110) begin errors++; $display("FAIL mw_stall cyc %0d got %b want %b", i, obs[4:0], 5'b11110); end
      tick();
    end
    mw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bubble_ID_EX === 1'b1) nb++;
      tick();
    end
    checks++;
    if (nb !== 1) begin errors++; $display("FAIL mw_bubble_once got %0d want %0d", nb, 1); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(2, 1, 2, 1, 6, 1, 0, 1, 0);
    #1;
    checks++;
    if (obs[4:0] !== 5'b00001) begin errors++; $display("FAIL flush_prio got %b want %b", obs[4:0], 5'b00001); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (obs[4:0] !== 5'b0) begin errors++; $display("FAIL flush_run got %b want %b", obs[4:0], 5'b0); end
    do_reset();
    drive(0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(2, 1, 2, 1, 6, 1, 0, 0, 0);
    tick();
    drive(2, 1, 2, 1, 6, 1, 0, 1, 0);
    #1;
    checks++;
    if (obs[4:0] !== 5'b00001) begin errors++; $display("FAIL flush_in_lu got %b want %b", obs[4:0], 5'b00001); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (obs[4:0] !== 5'b0) begin errors++; $display("FAIL flush_in_lu_run got %b want %b", obs[4:0], 5'b0); end
  endtask

  task automatic test_flush_memwait();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    checks++;
    if (obs[4:0] !== 5'b11110) begin errors++; $display("FAIL fmw_hold got %b want %b", obs[4:0], 5'b11110); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    mw = 1'b0;
    #1;
    checks++;
    if (obs[4:0] !== 5'b00001) begin errors++; $display("FAIL fmw_pending got %b want %b", obs[4:0], 5'b00001); end
    tick();
    #1;
    checks++;
    if (bubble_ID_EX !== 1'b0) begin errors++; $display("FAIL fmw_once got %b want %b", bubble_ID_EX, 1'b0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 9'b0) begin errors++; $display("FAIL rst_no_pending got %b want %b", obs, 9'b0); end
  endtask

  task automatic test_random();
    slot_t e = '0, d = '0;
    logic  pend = 0, b0e = 0, b0d = 0, b1e = 0, b1d = 0;
    logic  m0e, m1e, m0d, m1d, haz, fl, bub, sif;
    logic [8:0] exp_v;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive(4'($urandom_range(0, 3)), 1'($urandom % 4 != 0), 4'($urandom_range(0, 3)), 1'($urandom % 4 != 0),
            4'($urandom_range(0, 3)), 1'($urandom % 2), 1'b0, 1'($urandom % 8 == 0), 1'($urandom % 6 == 0));
      ld = we & ($urandom % 3 == 0);
      #1;
      m0e = u0 && e.v && e.we && e.dst == s0 && s0 != 0;
      m1e = u1 && e.v && e.we && e.dst == s1 && s1 != 0;
      m0d = u0 && d.v && d.we && d.dst == s0 && s0 != 0;
      m1d = u1 && d.v && d.we && d.dst == s1 && s1 != 0;
      haz = e.v && e.ld && (m0e || m1e);
      fl  = !mw && (flush || pend);
      bub = !mw && (fl || haz);
      sif = mw || (haz && !fl);
      exp_v = {b0e, b0d, b1e, b1d, sif, mw, mw, mw, bub};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rand cyc %0d got %b want %b", n, obs, exp_v); end
      if (!mw) begin
        d = e;
        e = bub ? '0 : {1'b1, we, ld, dst};
        b0e = m0e; b0d = m0d && !m0e; b1e = m1e; b1d = m1d && !m1e;
        pend = 1'b0;
      end else begin
        pend = pend || flush;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ex_bypass();
    test_dm_bypass();
    test_r0();
    test_load_use();
    test_lu_memwait();
    test_flush();
    test_flush_memwait();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
